// File: rtl/spi_master_pkg.sv
//------------------------------------------------------------------------------
// Module  : spi_defs (package)
// Brief   : Shared state encodings, SPI mode constants and default sizing.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spi_defs;
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam int c_DEFAULT_WIDTH   = 8;
    localparam int c_DEFAULT_CLK_DIV = 4;
endpackage

`default_nettype wire

// File: rtl/spi_master_if.sv
//------------------------------------------------------------------------------
// Module  : spi_master_if
// Brief   : Host handshake and serial pins of the SPI master; the loopback
//           select exists only when SPI_LOOPBACK_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_master_if import spi_defs::*; #(parameter int WIDTH = c_DEFAULT_WIDTH);
    logic             start;
    logic [WIDTH-1:0] txData;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rxData;
    logic             cs;
    logic             sclk;
    logic             mosi;
    logic             miso;
`ifdef SPI_LOOPBACK_EN
    logic             loopback;

    modport master (
        input  start, txData, miso, loopback,
        output busy, done, rxData, cs, sclk, mosi
    );
    modport slave (
        output start, txData, miso, loopback,
        input  busy, done, rxData, cs, sclk, mosi
    );
`else
    modport master (
        input  start, txData, miso,
        output busy, done, rxData, cs, sclk, mosi
    );
    modport slave (
        output start, txData, miso,
        input  busy, done, rxData, cs, sclk, mosi
    );
`endif
endinterface

`default_nettype wire

// File: rtl/spi_master_clk_gen.sv
//------------------------------------------------------------------------------
// Module  : spi_clk_gen
// Brief   : Registered half-period tick every CLK_DIV cycles while run is high.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic halfTick
);
    localparam int             c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_halfTick;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            r_cnt      <= '0;
            r_halfTick <= 1'b0;
        end else begin
            r_halfTick <= (r_cnt == c_LAST);
            r_cnt      <= (r_cnt == c_LAST) ? '0 : r_cnt + c_CW'(1);
        end
    end

    assign halfTick = r_halfTick;
endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//------------------------------------------------------------------------------
// Module  : spi_master
// Brief   : SPI mode-0 master, MSB first, one WIDTH-bit full-duplex transfer
//           per start. Optional SPI_LOOPBACK_EN samples mosi instead of miso.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_master import spi_defs::*; #(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int CLK_DIV = c_DEFAULT_CLK_DIV
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);
    localparam int c_CW = $clog2(WIDTH + 1);

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic [WIDTH-1:0] r_txShift;
    logic [WIDTH-1:0] r_rxShift;
    logic [WIDTH-1:0] r_rxData;
    logic [c_CW-1:0]  r_bitCnt;
    logic             r_sclk;
    logic             w_run;
    logic             w_halfTick;
    logic             w_sampleEdge;
    logic             w_lastEdge;
    logic             w_sampleBit;
    logic             w_busy;
    logic             w_done;
    logic             w_cs;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clkGen (
        .clk      (clk),
        .reset    (reset),
        .run      (w_run),
        .halfTick (w_halfTick)
    );

    // Sample on the edge leaving the idle level (mode 0: rising edge)
    assign w_sampleEdge = (r_sclk == SPI_CPOL) ^ SPI_CPHA;
    assign w_lastEdge   = !w_sampleEdge && (r_bitCnt == c_CW'(WIDTH));

`ifdef SPI_LOOPBACK_EN
    assign w_sampleBit = bus.loopback ? r_txShift[WIDTH-1] : bus.miso;
`else
    assign w_sampleBit = bus.miso;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_txShift <= '0;
            r_rxShift <= '0;
            r_rxData  <= '0;
            r_bitCnt  <= '0;
            r_sclk    <= SPI_CPOL;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_txShift <= bus.txData;
                        r_rxShift <= '0;
                        r_bitCnt  <= '0;
                    end
                end
                c_SHIFT: begin
                    if (w_halfTick) begin
                        r_sclk <= ~r_sclk;
                        if (w_sampleEdge) begin
                            r_rxShift <= {r_rxShift[WIDTH-2:0], w_sampleBit};
                            r_bitCnt  <= r_bitCnt + c_CW'(1);
                        end else if (!w_lastEdge) begin
                            r_txShift <= r_txShift << 1;
                        end
                    end
                end
                c_HOLD: begin
                    if (w_halfTick) begin
                        r_rxData <= r_rxShift;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (bus.start)                 w_nextState = c_SETUP;
            c_SETUP: if (w_halfTick)                w_nextState = c_SHIFT;
            c_SHIFT: if (w_halfTick && w_lastEdge)  w_nextState = c_HOLD;
            c_HOLD:  if (w_halfTick)                w_nextState = c_DONE;
            c_DONE:                                 w_nextState = c_IDLE;
            default:                                w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != c_IDLE);
        w_done = (r_state == c_DONE);
        w_run  = (r_state == c_SETUP) || (r_state == c_SHIFT) || (r_state == c_HOLD);
        w_cs   = !w_run;
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.cs     = w_cs;
    assign bus.sclk   = r_sclk;
    assign bus.mosi   = r_txShift[WIDTH-1];
    assign bus.rxData = r_rxData;
endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//------------------------------------------------------------------------------
// Module  : tb_spi_master
// Brief   : Self-checking bench for spi_master (8-bit/div-4 and 16-bit/div-1).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_master;
    import spi_defs::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    spi_master_if #(.WIDTH(8))  if0();
    spi_master_if #(.WIDTH(16)) if1();

    spi_master #(.WIDTH(8),  .CLK_DIV(4)) dut0 (.clk(clk), .reset(reset), .bus(if0.master));
    spi_master #(.WIDTH(16), .CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));

    // Peripheral shift register on dut0; dut1 has miso tied back to mosi
    logic [7:0] periph0 = '0;
    logic       forceLow0 = 1'b0;
    assign if0.miso = forceLow0 ? 1'b0 : periph0[7];
    assign if1.miso = if1.mosi;

    int         rises0 = 0, doneCnt0 = 0, csRise0 = 0;
    logic [7:0] mosiWord0 = '0;
    logic       prevSclk0 = 1'b0, prevCs0 = 1'b1;
    int          rises1 = 0, since1 = 0, gapMin1 = 1000, gapMax1 = 0;
    logic [15:0] mosiWord1 = '0;
    logic        prevSclk1 = 1'b0;

    always @(negedge clk) begin
        if (if0.sclk && !prevSclk0) begin
            rises0++;
            mosiWord0 = {mosiWord0[6:0], if0.mosi};
            periph0   = {periph0[6:0], if0.mosi};
        end
        if (if0.done) doneCnt0++;
        if (if0.cs && !prevCs0) csRise0++;
        prevSclk0 = if0.sclk;
        prevCs0   = if0.cs;
    end

    always @(negedge clk) begin
        if (if1.sclk && !prevSclk1) begin
            if (rises1 > 0) begin
                if (since1 < gapMin1) gapMin1 = since1;
                if (since1 > gapMax1) gapMax1 = since1;
            end
            since1 = 0;
            rises1++;
            mosiWord1 = {mosiWord1[14:0], if1.mosi};
        end
        since1++;
        prevSclk1 = if1.sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer0(input logic [7:0] tx, input logic [7:0] pre, input int p1, input int p2,
                         output int lat, output logic [7:0] rx);
        periph0   = pre;
        rises0    = 0;
        mosiWord0 = '0;
        @(negedge clk);
        if0.start  = 1'b1;
        if0.txData = tx;
        @(negedge clk);
        if0.start  = 1'b0;
        if0.txData = 8'($urandom);
        lat = 0;
        while (!if0.done && lat < 400) begin
            @(negedge clk);
            lat++;
            if0.start = (lat == p1) || (lat == p2);
        end
        if0.start = 1'b0;
        rx = if0.rxData;
    endtask

    task automatic chkXfer0(input string name, input logic [7:0] tx, input logic [7:0] expRx,
                            input logic [7:0] expPeriph, input int lat, input logic [7:0] rx);
        chk({name, ".rx"}, 32'(rx), 32'(expRx));
        chk({name, ".periph"}, 32'(periph0), 32'(expPeriph));
        chk({name, ".mosiBits"}, 32'(mosiWord0), 32'(tx));
        chk({name, ".rises"}, 32'(rises0), 32'd8);
        chk({name, ".latency"}, 32'(lat), 32'(1 + 4 * (2 * 8 + 2)));
        @(negedge clk);
        chk({name, ".doneOneCycle"}, 32'(if0.done), 32'd0);
        chk({name, ".busyDrops"}, 32'(if0.busy), 32'd0);
        chk({name, ".csHigh"}, 32'(if0.cs), 32'd1);
        chk({name, ".rxHeld"}, 32'(if0.rxData), 32'(expRx));
    endtask

    task automatic xfer1(input logic [15:0] tx, output int lat, output logic [15:0] rx);
        rises1 = 0; mosiWord1 = '0; gapMin1 = 1000; gapMax1 = 0;
        @(negedge clk);
        if1.start  = 1'b1;
        if1.txData = tx;
        @(negedge clk);
        if1.start  = 1'b0;
        if1.txData = 16'($urandom);
        lat = 0;
        while (!if1.done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        rx = if1.rxData;
    endtask

    task automatic chkXfer1(input string name, input logic [15:0] tx, input int lat, input logic [15:0] rx);
        chk({name, ".rx"}, 32'(rx), 32'(tx));
        chk({name, ".mosiBits"}, 32'(mosiWord1), 32'(tx));
        chk({name, ".rises"}, 32'(rises1), 32'd16);
        chk({name, ".latency"}, 32'(lat), 32'(1 + 1 * (2 * 16 + 2)));
        chk({name, ".periodMin"}, 32'(gapMin1), 32'd2);
        chk({name, ".periodMax"}, 32'(gapMax1), 32'd2);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] pre;
        logic [7:0] expRx;
        logic [7:0] expPeriph;
    } vec_t;

    initial begin
        vec_t        vecs[5];
        int          lat, n, d0, c0;
        logic [7:0]  tx8, pre8, rx8;
        logic [15:0] tx16, rx16;

        vecs[0] = '{8'h49, 8'hA5, 8'hA5, 8'h49};
        vecs[1] = '{8'h49, 8'h3C, 8'h3C, 8'h49};
        vecs[2] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
        vecs[3] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        vecs[4] = '{8'h81, 8'h7E, 8'h7E, 8'h81};

        if0.start = 1'b0; if0.txData = '0;
        if1.start = 1'b0; if1.txData = '0;
`ifdef SPI_LOOPBACK_EN
        if0.loopback = 1'b0;
        if1.loopback = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset.busy", 32'(if0.busy), 32'd0);
        chk("reset.done", 32'(if0.done), 32'd0);
        chk("reset.rxData", 32'(if0.rxData), 32'd0);
        chk("reset.cs", 32'(if0.cs), 32'd1);
        chk("reset.sclk", 32'(if0.sclk), 32'd0);
        chk("reset.mosi", 32'(if0.mosi), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            xfer0(vecs[i].tx, vecs[i].pre, -1, -1, lat, rx8);
            chkXfer0($sformatf("vec%0d", i), vecs[i].tx, vecs[i].expRx, vecs[i].expPeriph, lat, rx8);
        end

        for (int i = 0; i < 20; i++) begin
            tx8  = 8'($urandom);
            pre8 = 8'($urandom);
            xfer0(tx8, pre8, -1, -1, lat, rx8);
            chkXfer0($sformatf("rand%0d", i), tx8, pre8, tx8, lat, rx8);
        end

        // Extra start pulses mid-transfer, just before done and during done
        d0 = doneCnt0;
        c0 = csRise0;
        xfer0(8'h5A, 8'hC6, 10, 72, lat, rx8);
        chkXfer0("ignoreStart", 8'h5A, 8'hC6, 8'h5A, lat, rx8);
        repeat (150) @(negedge clk);
        d0 = doneCnt0 - d0;
        c0 = csRise0 - c0;
        chk("ignoreStart.donePulses", 32'(d0), 32'd1);
        chk("ignoreStart.csRises", 32'(c0), 32'd1);
        chk("ignoreStart.idle", 32'(if0.busy), 32'd0);

        d0 = doneCnt0;
        xfer0(8'h11, 8'h22, -1, -1, lat, rx8);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        repeat (120) @(negedge clk);
        chk("startInDone.donePulses", 32'(doneCnt0 - d0), 32'd1);

        // Reset after three bits of a transfer
        periph0 = 8'h5A;
        rises0  = 0;
        @(negedge clk);
        if0.start = 1'b1; if0.txData = 8'hF7;
        @(negedge clk);
        if0.start = 1'b0;
        n = 0;
        while (rises0 < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("abort.reachedBit3", 32'(rises0), 32'd3);
        d0 = doneCnt0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort.cs", 32'(if0.cs), 32'd1);
        chk("abort.sclk", 32'(if0.sclk), 32'd0);
        chk("abort.mosi", 32'(if0.mosi), 32'd0);
        chk("abort.busy", 32'(if0.busy), 32'd0);
        chk("abort.rxData", 32'(if0.rxData), 32'd0);
        chk("abort.done", 32'(if0.done), 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort.noDone", 32'(doneCnt0 - d0), 32'd0);
        xfer0(8'h3C, 8'h96, -1, -1, lat, rx8);
        chkXfer0("afterAbort", 8'h3C, 8'h96, 8'h3C, lat, rx8);

        xfer1(16'hBEEF, lat, rx16);
        chkXfer1("wide", 16'hBEEF, lat, rx16);
        for (int i = 0; i < 6; i++) begin
            tx16 = 16'($urandom);
            xfer1(tx16, lat, rx16);
            chkXfer1($sformatf("wideRand%0d", i), tx16, lat, rx16);
        end

`ifdef SPI_LOOPBACK_EN
        forceLow0    = 1'b1;
        if0.loopback = 1'b1;
        xfer0(8'hC3, 8'hFF, -1, -1, lat, rx8);
        chkXfer0("loopbackOn", 8'hC3, 8'hC3, 8'hC3, lat, rx8);
        if0.loopback = 1'b0;
        xfer0(8'hC3, 8'hFF, -1, -1, lat, rx8);
        chkXfer0("loopbackOff", 8'hC3, 8'h00, 8'hC3, lat, rx8);
        forceLow0 = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
